data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Single-port data memory controller for byte/half/word loads
//               and stores. It has a fixed, programmable latency: each
//               accepted request spends WAIT_STATES cycles in WAIT and then
//               one cycle in RESP. Misaligned, illegal-size and out-of-range
//               accesses fault without touching storage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH_WORDS  : number of 32-bit storage words
//   WAIT_STATES  : extra cycles per access (0..15)
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset (storage is not cleared)
//   req_valid    : request present          req_ready   : accepting (IDLE)
//   req_we       : 1 = store, 0 = load      req_addr    : byte address
//   req_wdata    : store data, right-aligned
//   req_size     : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned : loads: zero-extend (1) / sign-extend (0)
//   resp_valid   : one-cycle response pulse
//   resp_rdata   : extended load data (0 for stores/faults/idle)
//   resp_err     : access faulted, qualified by resp_valid
//   busy         : controller not in IDLE
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int       c_AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit [3:0] c_WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_busy;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  // Request captured at acceptance
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;

  logic [31:0] r_mem [DEPTH_WORDS];

  // With zero wait states the access completes on the accepting edge itself,
  // so in IDLE the live request is the one being serviced; afterwards only
  // the captured copy is used, which keeps in-flight accesses immune to
  // changes on req_*.
  logic            w_in_idle;
  logic            w_we;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [1:0]      w_size;
  logic            w_unsigned;
  logic [c_AW-1:0] w_idx;
  logic            w_fault;
  logic            w_enter_resp;
  logic            w_mem_we;
  logic [31:0]     w_rd_word;
  logic [31:0]     w_merged;
  logic [31:0]     w_load_ext;
  logic [31:0]     w_resp_data;

  assign w_in_idle  = (r_state == S_IDLE);
  assign w_we       = w_in_idle ? req_we       : r_we;
  assign w_addr     = w_in_idle ? req_addr     : r_addr;
  assign w_wdata    = w_in_idle ? req_wdata    : r_wdata;
  assign w_size     = w_in_idle ? req_size     : r_size;
  assign w_unsigned = w_in_idle ? req_unsigned : r_unsigned;

  assign w_idx      = w_addr[c_AW+1:2];
  assign w_rd_word  = r_mem[w_idx];

  // The range check uses the full word index so that high address bits
  // cannot alias onto a valid word.
  assign w_fault = (w_size == 2'b11)
                 || ((w_size == 2'b01) && w_addr[0])
                 || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))
                 || ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));

  assign w_enter_resp = (w_in_idle && req_valid && (c_WAIT_CNT == 4'd0))
                      || ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // Gated by rst so an edge seen during reset never commits a store
  assign w_mem_we = w_enter_resp && w_we && !w_fault && !rst;

  // Lane merge for stores: untouched lanes keep the current contents
  always_comb begin
    w_merged = w_rd_word;
    case (w_size)
      2'b00: begin
        case (w_addr[1:0])
          2'b00:   w_merged[7:0]   = w_wdata[7:0];
          2'b01:   w_merged[15:8]  = w_wdata[7:0];
          2'b10:   w_merged[23:16] = w_wdata[7:0];
          default: w_merged[31:24] = w_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (w_addr[1]) w_merged[31:16] = w_wdata[15:0];
        else           w_merged[15:0]  = w_wdata[15:0];
      end
      2'b10:   w_merged = w_wdata;
      default: w_merged = w_rd_word;
    endcase
  end

  // Load extraction and extension
  always_comb begin
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    v_byte     = 8'h00;
    v_half     = 16'h0000;
    w_load_ext = 32'h0;
    case (w_size)
      2'b00: begin
        case (w_addr[1:0])
          2'b00:   v_byte = w_rd_word[7:0];
          2'b01:   v_byte = w_rd_word[15:8];
          2'b10:   v_byte = w_rd_word[23:16];
          default: v_byte = w_rd_word[31:24];
        endcase
        w_load_ext = w_unsigned ? {24'h0, v_byte} : {{24{v_byte[7]}}, v_byte};
      end
      2'b01: begin
        v_half     = w_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        w_load_ext = w_unsigned ? {16'h0, v_half} : {{16{v_half[15]}}, v_half};
      end
      2'b10:   w_load_ext = w_rd_word;
      default: w_load_ext = 32'h0;
    endcase
  end

  assign w_resp_data = (w_we || w_fault) ? 32'h0 : w_load_ext;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
          if (req_valid) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_cnt      <= c_WAIT_CNT;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            if (c_WAIT_CNT == 4'd0) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_fault;
              r_resp_rdata <= w_resp_data;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Counter was loaded with WAIT_STATES; leaving on 1 keeps it from
          // ever wrapping below zero.
          if (r_cnt == 4'd1) begin
            r_state      <= S_RESP;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_fault;
            r_resp_rdata <= w_resp_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_busy       <= 1'b0;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_busy       <= 1'b0;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign busy       = r_busy;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed bench for data_mem_ctrl. Three instances cover
//               WAIT_STATES = 0, 1 and 3; request fields are shared and each
//               instance has its own req_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  vld;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [2:0]  rdy;
  logic [2:0]  rv;
  logic [2:0]  er;
  logic [2:0]  bsy;
  logic [31:0] rd [3];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  // idx 0: WAIT_STATES=0, idx 1: WAIT_STATES=1, idx 2: WAIT_STATES=3
  data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0]), .busy(bsy[0]));

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1]), .busy(bsy[1]));

  data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(er[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete access on instance s, started at a negedge. Returns the
  // response data/error, the latency in cycles from the accepting edge, and
  // ok=0 if no response came or the pulse was not exactly one cycle.
  task automatic access(input int s, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic un, output logic [31:0] rdata,
                        output logic e, output int lat, output logic ok);
    int n;
    ok = 1'b1;
    n  = 0;
    while (!rdy[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = un;
    vld[s] = 1'b1;
    @(posedge clk);
    #1;
    vld[s] = 1'b0;
    // Scramble the request lines while the access is in flight
    req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = ~wd;
    req_size = 2'b11; req_unsigned = ~un;
    lat = 1;
    while (!rv[s] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rv[s]) ok = 1'b0;
    rdata = rd[s];
    e     = er[s];
    @(posedge clk);
    #1;
    if (rv[s] || (rd[s] != 32'h0) || er[s]) ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (rdy !== 3'b111 || bsy !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready_busy: ready=%b busy=%b, want ready=111 busy=000", rdy, bsy);
    end
    checks++;
    if (rv !== 3'b000 || er !== 3'b000) begin
      errors++;
      $display("FAIL reset_resp: valid=%b err=%b, want 000/000", rv, er);
    end
    checks++;
    if (rd[0] !== 32'h0 || rd[1] !== 32'h0 || rd[2] !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h %h, want zeros", rd[0], rd[1], rd[2]);
    end
  endtask

  task automatic run_vectors(input string name, input int s, input int exp_lat,
                             input vec_t v [], input int nv);
    logic [31:0] got;
    logic        e;
    int          lat;
    logic        ok;
    for (int i = 0; i < nv; i++) begin
      access(s, v[i].we, v[i].a, v[i].wd, v[i].sz, v[i].un, got, e, lat, ok);
      checks++;
      if (got !== v[i].exp_rd) begin
        errors++;
        $display("FAIL %s[%0d] rdata: got %h, want %h", name, i, got, v[i].exp_rd);
      end
      checks++;
      if (e !== v[i].exp_err) begin
        errors++;
        $display("FAIL %s[%0d] err: got %b, want %b", name, i, e, v[i].exp_err);
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s[%0d] latency: got %0d, want %0d", name, i, lat, exp_lat);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s[%0d] pulse: response missing or not one cycle", name, i);
      end
    end
  endtask

  // WAIT_STATES=1: word/byte/half stores and loads, sign/zero extension
  task automatic test_store_load();
    vec_t v [];
    v = new[16];
    //          we    sz     un    addr         wdata         exp_rd        err
    v[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
    v[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'hABCDEF7F, 32'h00000000, 1'b0};
    v[3]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h0000007F, 1'b0};
    v[4]  = '{1'b1, 2'b00, 1'b0, 32'h12, 32'h12345680, 32'h00000000, 1'b0};
    v[5]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'hFFFFFF80, 1'b0};
    v[6]  = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'h00000080, 1'b0};
    v[7]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h7F80BEEF, 1'b0};
    v[8]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h00007F80, 1'b0};
    v[9]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0};
    v[10] = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h0000BEEF, 1'b0};
    v[11] = '{1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        32'h7F80BEEF, 1'b0};
    v[12] = '{1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFEF00D, 32'h00000000, 1'b0};
    v[13] = '{1'b1, 2'b01, 1'b0, 32'h0E, 32'h99991234, 32'h00000000, 1'b0};
    v[14] = '{1'b1, 2'b00, 1'b0, 32'h0D, 32'h66666655, 32'h00000000, 1'b0};
    v[15] = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        32'h1234550D, 1'b0};
    run_vectors("store_load", 1, 2, v, 16);
  endtask

  // WAIT_STATES=1: every fault kind, then confirm storage untouched
  task automatic test_faults();
    vec_t v [];
    v = new[11];
    v[0]  = '{1'b1, 2'b10, 1'b0, 32'h00,       32'h11111111, 32'h00000000, 1'b0};
    v[1]  = '{1'b0, 2'b01, 1'b0, 32'h11,       32'h0,        32'h00000000, 1'b1};
    v[2]  = '{1'b1, 2'b10, 1'b0, 32'h0E,       32'hFFFFFFFF, 32'h00000000, 1'b1};
    v[3]  = '{1'b1, 2'b11, 1'b0, 32'h10,       32'hFFFFFFFF, 32'h00000000, 1'b1};
    v[4]  = '{1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        32'h00000000, 1'b1};
    v[5]  = '{1'b1, 2'b10, 1'b0, 32'h1000,     32'h99999999, 32'h00000000, 1'b1};
    v[6]  = '{1'b0, 2'b10, 1'b0, 32'h1000,     32'h0,        32'h00000000, 1'b1};
    v[7]  = '{1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0,        32'h00000000, 1'b1};
    v[8]  = '{1'b0, 2'b10, 1'b0, 32'h0C,       32'h0,        32'h1234550D, 1'b0};
    v[9]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'h7F80BEEF, 1'b0};
    v[10] = '{1'b0, 2'b10, 1'b0, 32'h00,       32'h0,        32'h11111111, 1'b0};
    run_vectors("faults", 1, 2, v, 11);
  endtask

  // WAIT_STATES=0: req_valid held high over three loads
  task automatic test_back_to_back();
    vec_t v [];
    logic [31:0] exp_rd [3];
    logic        exp_rv;
    v = new[1];
    v[0] = '{1'b1, 2'b10, 1'b0, 32'h04, 32'hA5A50001, 32'h00000000, 1'b0};
    run_vectors("b2b_setup", 0, 1, v, 1);
    exp_rd[0] = 32'hA5A50001;
    exp_rd[1] = 32'h00000001;
    exp_rd[2] = 32'hFFFFA5A5;
    req_we = 1'b0; req_addr = 32'h04; req_size = 2'b10; req_unsigned = 1'b0;
    req_wdata = 32'h0;
    vld[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      exp_rv = ((k % 2) == 0);
      checks++;
      if (rv[0] !== exp_rv || rdy[0] !== ~exp_rv) begin
        errors++;
        $display("FAIL b2b_cycle%0d: valid=%b ready=%b, want valid=%b ready=%b",
                 k, rv[0], rdy[0], exp_rv, ~exp_rv);
      end
      checks++;
      if (rd[0] !== (exp_rv ? exp_rd[k/2] : 32'h0)) begin
        errors++;
        $display("FAIL b2b_data%0d: got %h, want %h", k, rd[0],
                 exp_rv ? exp_rd[k/2] : 32'h0);
      end
      // Present the next request right after each accepting edge
      if (k == 0) begin
        req_addr = 32'h04; req_size = 2'b00; req_unsigned = 1'b1;
      end else if (k == 2) begin
        req_addr = 32'h06; req_size = 2'b01; req_unsigned = 1'b0;
      end else if (k == 4) begin
        vld[0] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // WAIT_STATES=3: reset in the second WAIT cycle aborts a store
  task automatic test_abort();
    vec_t  v [];
    logic  seen;
    v = new[1];
    v[0] = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA5555, 32'h00000000, 1'b0};
    run_vectors("abort_setup", 2, 4, v, 1);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_size = 2'b10; req_unsigned = 1'b0;
    vld[2] = 1'b1;
    @(posedge clk);
    #1;
    vld[2] = 1'b0;
    checks++;
    if (bsy[2] !== 1'b1 || rdy[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait: busy=%b ready=%b, want busy=1 ready=0", bsy[2], rdy[2]);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bsy[2] !== 1'b0 || rdy[2] !== 1'b1 || rv[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b ready=%b valid=%b, want 0 1 0",
               bsy[2], rdy[2], rv[2]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (rv[2]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_resp: resp_valid=%b after abort, want 0", seen);
    end
    @(negedge clk);
    v[0] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0};
    run_vectors("abort_reload", 2, 4, v, 1);
  endtask

  initial begin
    rst = 1'b1;
    vld = 3'b000;
    req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b00; req_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_store_load();
    test_faults();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
